// File: rtl/mips_mem_responder.sv
// Shared instruction/data memory responder for a simple MIPS core.
//
// Two requesters (instruction fetch and data) share one word-addressed memory.
// At most one request is accepted per cycle. Data wins contention unless fetch
// has been passed over STARVE_MAX times in a row. Accepted requests travel down
// a LATENCY-deep shift pipeline, so responses leave in acceptance order exactly
// LATENCY cycles after acceptance. There is no response back-pressure.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   if_req_valid_i/addr_i   fetch read request (word address)
//   if_req_ready_o          fetch request accepted this cycle
//   if_rsp_valid_o/data_o   fetch response strobe and instruction word
//   if_rsp_err_o            fetch address was out of range
//   dm_req_valid_i/we_i     data request, we=1 store / we=0 load
//   dm_req_addr_i/wdata_i   data word address and store data
//   dm_req_ready_o          data request accepted this cycle
//   dm_rsp_valid_o/data_o   data response strobe and load data (0 for stores)
//   dm_rsp_err_o            data address was out of range
//   busy_o                  any response still in flight
module mips_mem_responder #(
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        if_req_valid_i,
    input  logic [31:0] if_req_addr_i,
    output logic        if_req_ready_o,
    output logic        if_rsp_valid_o,
    output logic [31:0] if_rsp_data_o,
    output logic        if_rsp_err_o,

    input  logic        dm_req_valid_i,
    input  logic        dm_req_we_i,
    input  logic [31:0] dm_req_addr_i,
    input  logic [31:0] dm_req_wdata_i,
    output logic        dm_req_ready_o,
    output logic        dm_rsp_valid_o,
    output logic [31:0] dm_rsp_data_o,
    output logic        dm_rsp_err_o,

    output logic        busy_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [31:0]   DepthW     = 32'(DEPTH);
    localparam logic [SW-1:0] StarveMaxW = SW'(STARVE_MAX);

    typedef struct packed {
        logic        valid;
        logic        port_dm;   // 1 = data port, 0 = fetch port
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic [31:0]   mem_q [DEPTH];
    rsp_t          pipe_q [LATENCY];
    rsp_t          entry_d;
    logic [SW-1:0] starve_q, starve_d;

    logic          starve_hit;
    logic          grant_dm, grant_if;
    logic [31:0]   acc_addr;
    logic          acc_in_range;
    logic [AW-1:0] acc_idx;
    logic [31:0]   rd_word;
    logic          mem_we;
    rsp_t          last;

    // Arbitration and request decode. Grants are held off while in reset so
    // nothing is accepted (and nothing written) until rst_i drops.
    always_comb begin
        starve_hit   = (starve_q == StarveMaxW);
        grant_dm     = !rst_i && dm_req_valid_i && !(if_req_valid_i && starve_hit);
        grant_if     = !rst_i && if_req_valid_i && !grant_dm;
        acc_addr     = grant_dm ? dm_req_addr_i : if_req_addr_i;
        acc_in_range = (acc_addr < DepthW);
        acc_idx      = acc_addr[AW-1:0];
        mem_we       = grant_dm && dm_req_we_i && acc_in_range;

        rd_word = '0;
        if (acc_in_range) begin
            rd_word = mem_q[acc_idx];
        end

        entry_d         = '0;
        entry_d.valid   = grant_dm || grant_if;
        entry_d.port_dm = grant_dm;
        entry_d.err     = entry_d.valid && !acc_in_range;
        if (entry_d.valid && !(grant_dm && dm_req_we_i)) begin
            entry_d.data = rd_word;
        end
    end

    // Starve counter only tracks data grants while fetch is actually waiting.
    always_comb begin
        starve_d = starve_q;
        if (!if_req_valid_i || grant_if) begin
            starve_d = '0;
        end else if (grant_dm && !starve_hit) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    // Memory is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[acc_idx] <= dm_req_wdata_i;
        end
    end

    // Response shift pipeline; reset discards anything in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= entry_d;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    always_comb begin
        last           = pipe_q[LATENCY-1];
        if_req_ready_o = grant_if;
        dm_req_ready_o = grant_dm;

        if_rsp_valid_o = last.valid && !last.port_dm;
        if_rsp_data_o  = if_rsp_valid_o ? last.data : '0;
        if_rsp_err_o   = if_rsp_valid_o && last.err;

        dm_rsp_valid_o = last.valid && last.port_dm;
        dm_rsp_data_o  = dm_rsp_valid_o ? last.data : '0;
        dm_rsp_err_o   = dm_rsp_valid_o && last.err;

        busy_o = 1'b0;
        for (int unsigned i = 0; i < LATENCY; i++) begin
            busy_o = busy_o | pipe_q[i].valid;
        end
    end

endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed bench for mips_mem_responder. Three instances share one stimulus
// stream: LATENCY=2 (default, main checks), LATENCY=1 and LATENCY=4.
module tb_mips_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid;
    logic [31:0] if_req_addr;
    logic        dm_req_valid, dm_req_we;
    logic [31:0] dm_req_addr, dm_req_wdata;

    logic        a_if_ready, a_if_valid, a_if_err, a_dm_ready, a_dm_valid, a_dm_err, a_busy;
    logic [31:0] a_if_data, a_dm_data;
    logic        b_if_ready, b_if_valid, b_if_err, b_dm_ready, b_dm_valid, b_dm_err, b_busy;
    logic [31:0] b_if_data, b_dm_data;
    logic        c_if_ready, c_if_valid, c_if_err, c_dm_ready, c_dm_valid, c_dm_err, c_busy;
    logic [31:0] c_if_data, c_dm_data;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    mips_mem_responder #(.DEPTH(1024), .LATENCY(2), .STARVE_MAX(4)) u_a (
        .clk_i(clk), .rst_i(rst),
        .if_req_valid_i(if_req_valid), .if_req_addr_i(if_req_addr), .if_req_ready_o(a_if_ready),
        .if_rsp_valid_o(a_if_valid), .if_rsp_data_o(a_if_data), .if_rsp_err_o(a_if_err),
        .dm_req_valid_i(dm_req_valid), .dm_req_we_i(dm_req_we), .dm_req_addr_i(dm_req_addr),
        .dm_req_wdata_i(dm_req_wdata), .dm_req_ready_o(a_dm_ready),
        .dm_rsp_valid_o(a_dm_valid), .dm_rsp_data_o(a_dm_data), .dm_rsp_err_o(a_dm_err),
        .busy_o(a_busy)
    );

    mips_mem_responder #(.DEPTH(1024), .LATENCY(1), .STARVE_MAX(4)) u_b (
        .clk_i(clk), .rst_i(rst),
        .if_req_valid_i(if_req_valid), .if_req_addr_i(if_req_addr), .if_req_ready_o(b_if_ready),
        .if_rsp_valid_o(b_if_valid), .if_rsp_data_o(b_if_data), .if_rsp_err_o(b_if_err),
        .dm_req_valid_i(dm_req_valid), .dm_req_we_i(dm_req_we), .dm_req_addr_i(dm_req_addr),
        .dm_req_wdata_i(dm_req_wdata), .dm_req_ready_o(b_dm_ready),
        .dm_rsp_valid_o(b_dm_valid), .dm_rsp_data_o(b_dm_data), .dm_rsp_err_o(b_dm_err),
        .busy_o(b_busy)
    );

    mips_mem_responder #(.DEPTH(1024), .LATENCY(4), .STARVE_MAX(4)) u_c (
        .clk_i(clk), .rst_i(rst),
        .if_req_valid_i(if_req_valid), .if_req_addr_i(if_req_addr), .if_req_ready_o(c_if_ready),
        .if_rsp_valid_o(c_if_valid), .if_rsp_data_o(c_if_data), .if_rsp_err_o(c_if_err),
        .dm_req_valid_i(dm_req_valid), .dm_req_we_i(dm_req_we), .dm_req_addr_i(dm_req_addr),
        .dm_req_wdata_i(dm_req_wdata), .dm_req_ready_o(c_dm_ready),
        .dm_rsp_valid_o(c_dm_valid), .dm_rsp_data_o(c_dm_data), .dm_rsp_err_o(c_dm_err),
        .busy_o(c_busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Move to just after the next rising edge; inputs set here apply to the following edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req_valid = 1'b0;
        if_req_addr  = '0;
        dm_req_valid = 1'b0;
        dm_req_we    = 1'b0;
        dm_req_addr  = '0;
        dm_req_wdata = '0;
    endtask

    task automatic dm_drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        dm_req_valid = 1'b1;
        dm_req_we    = we;
        dm_req_addr  = addr;
        dm_req_wdata = wdata;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] wdata);
        cyc();
        idle_inputs();
        dm_drive(1'b1, addr, wdata);
        cyc();
        idle_inputs();
    endtask

    task automatic drain();
        repeat (6) cyc();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "bench timed out");
    end

    initial begin : stim
        logic [9:0] pat;
        pat = 10'b0_1111_0_1111;   // bit j = 1 -> data granted in cycle j
        rst = 1'b1;
        idle_inputs();

        // Reset state, including requests ignored while in reset.
        repeat (2) @(posedge clk);
        #1;
        dm_drive(1'b1, 32'd0, 32'h0);
        @(negedge clk);
        check_eq("rst_if_rsp_valid", 32'(a_if_valid), 32'd0);
        check_eq("rst_dm_rsp_valid", 32'(a_dm_valid), 32'd0);
        check_eq("rst_dm_rsp_data", a_dm_data, 32'd0);
        check_eq("rst_busy", 32'(a_busy), 32'd0);
        check_eq("rst_dm_ready", 32'(a_dm_ready), 32'd0);
        check_eq("rst_starve", 32'(u_a.starve_q), 32'd0);

        // Fetch alone, first edge after reset release.
        cyc();
        rst = 1'b0;
        idle_inputs();
        if_req_valid = 1'b1;
        if_req_addr  = 32'd0;
        @(negedge clk);
        check_eq("solo_if_ready", 32'(a_if_ready), 32'd1);
        check_eq("solo_dm_ready", 32'(a_dm_ready), 32'd0);
        cyc();
        @(negedge clk);
        check_eq("solo_if_ready2", 32'(a_if_ready), 32'd1);
        check_eq("solo_starve", 32'(u_a.starve_q), 32'd0);
        cyc();
        idle_inputs();
        drain();

        // Store then load same address back-to-back.
        cyc();
        dm_drive(1'b1, 32'd5, 32'hDEADBEEF);
        @(negedge clk);
        check_eq("st5_ready", 32'(a_dm_ready), 32'd1);
        check_eq("st5_rsp_early", 32'(a_dm_valid), 32'd0);
        cyc();
        dm_drive(1'b0, 32'd5, 32'h0);
        @(negedge clk);
        check_eq("ld5_ready", 32'(a_dm_ready), 32'd1);
        check_eq("ld5_rsp_early", 32'(a_dm_valid), 32'd0);
        cyc();
        idle_inputs();
        @(negedge clk);
        check_eq("st5_rsp_valid", 32'(a_dm_valid), 32'd1);
        check_eq("st5_rsp_data", a_dm_data, 32'd0);
        check_eq("st5_rsp_err", 32'(a_dm_err), 32'd0);
        check_eq("st5_busy", 32'(a_busy), 32'd1);
        cyc();
        @(negedge clk);
        check_eq("ld5_rsp_valid", 32'(a_dm_valid), 32'd1);
        check_eq("ld5_rsp_data", a_dm_data, 32'hDEADBEEF);
        check_eq("ld5_rsp_err", 32'(a_dm_err), 32'd0);
        cyc();
        @(negedge clk);
        check_eq("ld5_after_valid", 32'(a_dm_valid), 32'd0);
        check_eq("ld5_after_data", a_dm_data, 32'd0);
        check_eq("ld5_after_busy", 32'(a_busy), 32'd0);

        // Contention: both ports valid for 10 cycles.
        store(32'd10, 32'h1111_0010);
        store(32'd20, 32'h2222_0020);
        drain();
        for (int j = 0; j < 12; j++) begin
            cyc();
            idle_inputs();
            if (j < 10) begin
                if_req_valid = 1'b1;
                if_req_addr  = 32'd10;
                dm_drive(1'b0, 32'd20, 32'h0);
            end
            @(negedge clk);
            if (j < 10) begin
                check_eq($sformatf("arb_dm_ready[%0d]", j), 32'(a_dm_ready), 32'(pat[j]));
                check_eq($sformatf("arb_if_ready[%0d]", j), 32'(a_if_ready), 32'(!pat[j]));
            end
            if (j >= 2) begin
                check_eq($sformatf("arb_dm_rsp[%0d]", j), 32'(a_dm_valid), 32'(pat[j-2]));
                check_eq($sformatf("arb_if_rsp[%0d]", j), 32'(a_if_valid), 32'(!pat[j-2]));
                if (pat[j-2]) check_eq($sformatf("arb_dm_data[%0d]", j), a_dm_data, 32'h2222_0020);
                else          check_eq($sformatf("arb_if_data[%0d]", j), a_if_data, 32'h1111_0010);
            end
        end
        drain();

        // Out-of-range accesses; 2000 aliases 976 in the low address bits.
        store(32'd976, 32'h0000_0976);
        drain();
        cyc();
        dm_drive(1'b1, 32'd2000, 32'h00BA_DBAD);
        cyc();
        dm_drive(1'b0, 32'd1024, 32'h0);
        cyc();
        dm_drive(1'b0, 32'd2000, 32'h0);
        @(negedge clk);
        check_eq("oor_st_valid", 32'(a_dm_valid), 32'd1);
        check_eq("oor_st_err", 32'(a_dm_err), 32'd1);
        cyc();
        dm_drive(1'b0, 32'd976, 32'h0);
        @(negedge clk);
        check_eq("oor_ld1024_err", 32'(a_dm_err), 32'd1);
        check_eq("oor_ld1024_data", a_dm_data, 32'd0);
        cyc();
        idle_inputs();
        @(negedge clk);
        check_eq("oor_ld2000_err", 32'(a_dm_err), 32'd1);
        check_eq("oor_ld2000_data", a_dm_data, 32'd0);
        cyc();
        @(negedge clk);
        check_eq("alias976_valid", 32'(a_dm_valid), 32'd1);
        check_eq("alias976_data", a_dm_data, 32'h0000_0976);
        check_eq("alias976_err", 32'(a_dm_err), 32'd0);
        drain();

        // Reset with responses in flight.
        store(32'd3, 32'h3333_3333);
        drain();
        cyc();
        dm_drive(1'b1, 32'd7, 32'h7777_7777);
        cyc();
        idle_inputs();
        if_req_valid = 1'b1;
        if_req_addr  = 32'd3;
        @(negedge clk);
        check_eq("pre_rst_if_ready", 32'(a_if_ready), 32'd1);
        cyc();
        idle_inputs();
        rst = 1'b1;
        #1;
        check_eq("rst_async_busy", 32'(a_busy), 32'd0);
        check_eq("rst_async_dm_valid", 32'(a_dm_valid), 32'd0);
        cyc();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq($sformatf("post_rst_if_rsp[%0d]", k), 32'(a_if_valid), 32'd0);
            check_eq($sformatf("post_rst_dm_rsp[%0d]", k), 32'(a_dm_valid), 32'd0);
            cyc();
        end
        if_req_valid = 1'b1;
        if_req_addr  = 32'd3;
        cyc();
        idle_inputs();
        dm_drive(1'b0, 32'd7, 32'h0);
        cyc();
        idle_inputs();
        @(negedge clk);
        check_eq("refetch3_valid", 32'(a_if_valid), 32'd1);
        check_eq("refetch3_data", a_if_data, 32'h3333_3333);
        cyc();
        @(negedge clk);
        check_eq("reload7_valid", 32'(a_dm_valid), 32'd1);
        check_eq("reload7_data", a_dm_data, 32'h7777_7777);
        drain();

        // Latency variants: one load of addr 5 seen by all three instances.
        for (int k = 0; k < 6; k++) begin
            cyc();
            idle_inputs();
            if (k == 0) dm_drive(1'b0, 32'd5, 32'h0);
            @(negedge clk);
            check_eq($sformatf("lat1_valid[%0d]", k), 32'(b_dm_valid), 32'(k == 1));
            check_eq($sformatf("lat1_busy[%0d]", k), 32'(b_busy), 32'(k == 1));
            check_eq($sformatf("lat2_valid[%0d]", k), 32'(a_dm_valid), 32'(k == 2));
            check_eq($sformatf("lat4_valid[%0d]", k), 32'(c_dm_valid), 32'(k == 4));
            check_eq($sformatf("lat4_busy[%0d]", k), 32'(c_busy), 32'(k >= 1 && k <= 4));
            if (k == 1) check_eq("lat1_data", b_dm_data, 32'hDEADBEEF);
            if (k == 4) check_eq("lat4_data", c_dm_data, 32'hDEADBEEF);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
